// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Master game FSM for Flappy-VGA. Turns the start and ack buttons into clean
// one-cycle events and drives one start/stop/ack protocol for the X RAM, the
// Y ROM, flight control and the collision/coin logic. It also owns the score,
// the high score, the countdown and the one-hot state flags for the display.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   tick         one-cycle game-tick strobe, synchronous to clk
//   btn_start    raw start button level (asynchronous)
//   btn_ack      raw ack/abort button level (asynchronous)
//   lose         collision level from obstacle_logic
//   coin_hit     coin-collected level from coin_logic
//   start_pulse  one-cycle start to x_ram / y_rom / flight_control
//   stop         freeze level to x_ram / flight_control
//   ack_pulse    one-cycle ack/clear to all game blocks
//   q_idle .. q_over  one-hot state flags
//   countdown    remaining countdown ticks, saturating at 3
//   score        current score, saturating at SCORE_MAX
//   hi_score     best score since reset
//   new_hi       set when the last finished game beat hi_score
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int COUNT_TICKS = 3,
  parameter int DIE_TICKS   = 60,
  parameter int SCORE_W     = 10,
  parameter int SCORE_MAX   = 999
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               btn_start,
  input  logic               btn_ack,
  input  logic               lose,
  input  logic               coin_hit,
  output logic               start_pulse,
  output logic               stop,
  output logic               ack_pulse,
  output logic               q_idle,
  output logic               q_count,
  output logic               q_play,
  output logic               q_dying,
  output logic               q_over,
  output logic [1:0]         countdown,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_hi
);

  localparam int CNT_W = 16;

  // One-hot encoding so each state flag is a direct flop output.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_COUNT = 5'b00010,
    ST_PLAY  = 5'b00100,
    ST_DYING = 5'b01000,
    ST_OVER  = 5'b10000
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   die_q, die_d;
  logic               start_s1_q, start_s1_d, start_s2_q, start_s2_d;
  logic               start_prev_q, start_prev_d;
  logic               ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;
  logic               ack_prev_q, ack_prev_d;
  logic               coin_prev_q, coin_prev_d;
  logic               start_pulse_q, start_pulse_d;
  logic               ack_pulse_q, ack_pulse_d;
  logic               stop_q, stop_d;
  logic [1:0]         countdown_q, countdown_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic               new_hi_q, new_hi_d;
  logic               start_e, ack_e, coin_e;

  // The display only has room for 0..3 on the countdown.
  function automatic logic [1:0] sat_cd(input logic [CNT_W-1:0] v);
    return (v > CNT_W'(3)) ? 2'd3 : v[1:0];
  endfunction

  // Next-state logic: button synchronisers, edge detects and the game FSM.
  always_comb begin
    start_s1_d   = btn_start;
    start_s2_d   = start_s1_q;
    start_prev_d = start_s2_q;
    ack_s1_d     = btn_ack;
    ack_s2_d     = ack_s1_q;
    ack_prev_d   = ack_s2_q;
    coin_prev_d  = coin_hit;

    start_e = start_s2_q & ~start_prev_q;
    ack_e   = ack_s2_q & ~ack_prev_q;
    coin_e  = coin_hit & ~coin_prev_q;

    state_d       = state_q;
    cnt_d         = cnt_q;
    die_d         = die_q;
    stop_d        = stop_q;
    countdown_d   = countdown_q;
    score_d       = score_q;
    hi_d          = hi_q;
    new_hi_d      = new_hi_q;
    start_pulse_d = 1'b0;
    ack_pulse_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stop_d      = 1'b0;
        countdown_d = 2'd0;
        // Ack has priority over a simultaneous start.
        if (ack_e) begin
          ack_pulse_d = 1'b1;
        end else if (start_e) begin
          score_d  = '0;
          new_hi_d = 1'b0;
          if (COUNT_TICKS == 0) begin
            state_d       = ST_PLAY;
            start_pulse_d = 1'b1;
          end else begin
            state_d     = ST_COUNT;
            cnt_d       = CNT_W'(COUNT_TICKS);
            countdown_d = sat_cd(CNT_W'(COUNT_TICKS));
          end
        end
      end

      ST_COUNT: begin
        if (ack_e) begin
          state_d     = ST_IDLE;
          ack_pulse_d = 1'b1;
          stop_d      = 1'b0;
          countdown_d = 2'd0;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d       = ST_PLAY;
            start_pulse_d = 1'b1;
            cnt_d         = '0;
            countdown_d   = 2'd0;
          end else begin
            cnt_d       = cnt_q - CNT_W'(1);
            countdown_d = sat_cd(cnt_q - CNT_W'(1));
          end
        end
      end

      ST_PLAY: begin
        stop_d = 1'b0;
        if (ack_e) begin
          state_d     = ST_IDLE;
          ack_pulse_d = 1'b1;
        end else begin
          // A coin arriving together with the collision is still counted.
          if (coin_e && (score_q < SCORE_W'(SCORE_MAX))) begin
            score_d = score_q + SCORE_W'(1);
          end
          if (lose) begin
            state_d = ST_DYING;
            stop_d  = 1'b1;
            die_d   = '0;
          end
        end
      end

      ST_DYING: begin
        stop_d = 1'b1;
        if (ack_e) begin
          state_d     = ST_IDLE;
          ack_pulse_d = 1'b1;
          stop_d      = 1'b0;
        end else if (tick) begin
          if (die_q >= CNT_W'(DIE_TICKS - 1)) begin
            state_d = ST_OVER;
            if (score_q > hi_q) begin
              hi_d     = score_q;
              new_hi_d = 1'b1;
            end
          end else begin
            die_d = die_q + CNT_W'(1);
          end
        end
      end

      ST_OVER: begin
        stop_d = 1'b1;
        if (ack_e) begin
          state_d     = ST_IDLE;
          ack_pulse_d = 1'b1;
          stop_d      = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        stop_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs, cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      die_q         <= '0;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_prev_q  <= 1'b0;
      ack_s1_q      <= 1'b0;
      ack_s2_q      <= 1'b0;
      ack_prev_q    <= 1'b0;
      coin_prev_q   <= 1'b0;
      start_pulse_q <= 1'b0;
      ack_pulse_q   <= 1'b0;
      stop_q        <= 1'b0;
      countdown_q   <= 2'd0;
      score_q       <= '0;
      hi_q          <= '0;
      new_hi_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      die_q         <= die_d;
      start_s1_q    <= start_s1_d;
      start_s2_q    <= start_s2_d;
      start_prev_q  <= start_prev_d;
      ack_s1_q      <= ack_s1_d;
      ack_s2_q      <= ack_s2_d;
      ack_prev_q    <= ack_prev_d;
      coin_prev_q   <= coin_prev_d;
      start_pulse_q <= start_pulse_d;
      ack_pulse_q   <= ack_pulse_d;
      stop_q        <= stop_d;
      countdown_q   <= countdown_d;
      score_q       <= score_d;
      hi_q          <= hi_d;
      new_hi_q      <= new_hi_d;
    end
  end

  assign q_idle      = state_q[0];
  assign q_count     = state_q[1];
  assign q_play      = state_q[2];
  assign q_dying     = state_q[3];
  assign q_over      = state_q[4];
  assign start_pulse = start_pulse_q;
  assign ack_pulse   = ack_pulse_q;
  assign stop        = stop_q;
  assign countdown   = countdown_q;
  assign score       = score_q;
  assign hi_score    = hi_q;
  assign new_hi      = new_hi_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
// Directed game scenarios with randomised coin counts, hold lengths and tick
// spacing. Expected score/high-score/flags come from a small game-level model
// (coin count with saturation, max of finished scores, named game phase).
// ---------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int SMAX = 999;

  localparam logic [4:0] F_IDLE  = 5'b10000;
  localparam logic [4:0] F_COUNT = 5'b01000;
  localparam logic [4:0] F_PLAY  = 5'b00100;
  localparam logic [4:0] F_DYING = 5'b00010;
  localparam logic [4:0] F_OVER  = 5'b00001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, btn_start, btn_ack, lose, coin_hit;
  logic       start_pulse, stop, ack_pulse;
  logic       q_idle, q_count, q_play, q_dying, q_over;
  logic [1:0] countdown;
  logic [9:0] score, hi_score;
  logic       new_hi;
  logic [4:0] flags;

  int vectors     = 0;
  int miscompares = 0;

  // Game-level reference model.
  int exp_score  = 0;
  int exp_hi     = 0;
  int exp_new_hi = 0;

  assign flags = {q_idle, q_count, q_play, q_dying, q_over};

  always #5 clk = ~clk;

  game_sequencer #(
    .COUNT_TICKS(3),
    .DIE_TICKS  (60),
    .SCORE_W    (10),
    .SCORE_MAX  (SMAX)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .btn_start  (btn_start),
    .btn_ack    (btn_ack),
    .lose       (lose),
    .coin_hit   (coin_hit),
    .start_pulse(start_pulse),
    .stop       (stop),
    .ack_pulse  (ack_pulse),
    .q_idle     (q_idle),
    .q_count    (q_count),
    .q_play     (q_play),
    .q_dying    (q_dying),
    .q_over     (q_over),
    .countdown  (countdown),
    .score      (score),
    .hi_score   (hi_score),
    .new_hi     (new_hi)
  );

  function automatic int coin_add(input int s);
    return (s >= SMAX) ? SMAX : s + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic t,
                               input logic l, input logic c);
    btn_start = s;
    btn_ack   = a;
    tick      = t;
    lose      = l;
    coin_hit  = c;
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
  endtask

  task automatic check_game(input string tag, input logic [4:0] fexp,
                            input logic stop_exp);
    checkOutput({tag, "_flags"}, 32'(flags), 32'(fexp));
    checkOutput({tag, "_score"}, 32'(score), 32'(exp_score));
    checkOutput({tag, "_hi"}, 32'(hi_score), 32'(exp_hi));
    checkOutput({tag, "_new_hi"}, 32'(new_hi), 32'(exp_new_hi));
    checkOutput({tag, "_stop"}, 32'(stop), 32'(stop_exp));
  endtask

  // A coin rise; counts only when the game is in play.
  task automatic coin_press(input int hold, input bit counts);
    coin_hit = 1'b1;
    cycles(1);
    if (counts) exp_score = coin_add(exp_score);
    checkOutput("coin_rise_score", 32'(score), 32'(exp_score));
    if (hold > 1) begin
      cycles(hold - 1);
      checkOutput("coin_held_score", 32'(score), 32'(exp_score));
    end
    coin_hit = 1'b0;
    cycles(1 + $urandom_range(0, 2));
  endtask

  // Start button from IDLE into COUNT: three clocks from raw rise.
  task automatic start_game();
    btn_start = 1'b1;
    cycles(2);
    checkOutput("start_sync_delay", 32'(flags), 32'(F_IDLE));
    cycles(1);
    exp_score  = 0;
    exp_new_hi = 0;
    check_game("count_entry", F_COUNT, 1'b0);
    checkOutput("count_entry_cd", 32'(countdown), 32'd3);
    btn_start = 1'b0;
  endtask

  task automatic run_countdown();
    cycles($urandom_range(0, 3));
    checkOutput("cd_idle_ticks_3", 32'(countdown), 32'd3);
    pulse_tick();
    checkOutput("cd_2", 32'(countdown), 32'd2);
    cycles($urandom_range(0, 3));
    pulse_tick();
    checkOutput("cd_1", 32'(countdown), 32'd1);
    checkOutput("cd_1_flags", 32'(flags), 32'(F_COUNT));
    checkOutput("cd_no_start_yet", 32'(start_pulse), 32'd0);
    cycles($urandom_range(0, 3));
    pulse_tick();
    checkOutput("play_entry_flags", 32'(flags), 32'(F_PLAY));
    checkOutput("start_pulse_hi", 32'(start_pulse), 32'd1);
    cycles(1);
    checkOutput("start_pulse_lo", 32'(start_pulse), 32'd0);
  endtask

  // Collision while a coin edge arrives in the same cycle.
  task automatic lose_with_coin();
    coin_hit = 1'b1;
    lose     = 1'b1;
    cycles(1);
    exp_score = coin_add(exp_score);
    check_game("lose_coin", F_DYING, 1'b1);
    coin_hit = 1'b0;
    lose     = 1'b0;
    cycles(1);
  endtask

  task automatic run_dying();
    for (int i = 0; i < 59; i++) begin
      pulse_tick();
      cycles($urandom_range(0, 1));
    end
    check_game("dying_59", F_DYING, 1'b1);
    pulse_tick();
    if (exp_score > exp_hi) begin
      exp_hi     = exp_score;
      exp_new_hi = 1;
    end
    check_game("over_entry", F_OVER, 1'b1);
  endtask

  initial begin
    int n_coins;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    cycles(2);
    check_game("in_reset", F_IDLE, 1'b0);
    reset_n = 1'b1;
    cycles(3);
    check_game("after_reset", F_IDLE, 1'b0);
    checkOutput("reset_start_pulse", 32'(start_pulse), 32'd0);
    checkOutput("reset_ack_pulse", 32'(ack_pulse), 32'd0);
    checkOutput("reset_countdown", 32'(countdown), 32'd0);

    $display("[TB] ticks and coins in IDLE are ignored");
    pulse_tick();
    coin_press(2, 1'b0);
    check_game("idle_ignore", F_IDLE, 1'b0);

    $display("[TB] game 1: countdown, coins, lose+coin, dying, over");
    start_game();
    run_countdown();
    n_coins = $urandom_range(4, 8);
    coin_press(10, 1'b1);
    for (int i = 1; i < n_coins; i++) coin_press($urandom_range(1, 4), 1'b1);
    btn_start = 1'b1;
    cycles(4);
    btn_start = 1'b0;
    check_game("play_start_ignored", F_PLAY, 1'b0);
    cycles(3);
    lose_with_coin();
    coin_press(2, 1'b0);
    run_dying();

    $display("[TB] OVER: start ignored, ack returns to IDLE");
    btn_start = 1'b1;
    cycles(4);
    btn_start = 1'b0;
    check_game("over_start_ignored", F_OVER, 1'b1);
    cycles(3);
    btn_ack = 1'b1;
    cycles(2);
    checkOutput("over_ack_sync", 32'(flags), 32'(F_OVER));
    cycles(1);
    check_game("over_ack", F_IDLE, 1'b0);
    checkOutput("over_ack_pulse_hi", 32'(ack_pulse), 32'd1);
    cycles(1);
    checkOutput("over_ack_pulse_lo", 32'(ack_pulse), 32'd0);
    btn_ack = 1'b0;
    cycles(3);

    $display("[TB] game 2: abort from PLAY keeps hi_score");
    start_game();
    run_countdown();
    n_coins = $urandom_range(1, 3);
    for (int i = 0; i < n_coins; i++) coin_press($urandom_range(1, 3), 1'b1);
    btn_ack = 1'b1;
    cycles(2);
    checkOutput("abort_sync", 32'(flags), 32'(F_PLAY));
    cycles(1);
    check_game("abort", F_IDLE, 1'b0);
    checkOutput("abort_ack_pulse", 32'(ack_pulse), 32'd1);
    btn_ack = 1'b0;
    cycles(3);

    $display("[TB] IDLE: start and ack together, ack wins");
    btn_start = 1'b1;
    btn_ack   = 1'b1;
    cycles(3);
    check_game("start_ack_tie", F_IDLE, 1'b0);
    checkOutput("start_ack_tie_pulse", 32'(ack_pulse), 32'd1);
    btn_start = 1'b0;
    btn_ack   = 1'b0;
    cycles(3);

    $display("[TB] game 3: score saturation");
    start_game();
    run_countdown();
    for (int i = 0; i < 1000; i++) begin
      coin_hit = 1'b1;
      cycles(1);
      exp_score = coin_add(exp_score);
      coin_hit = 1'b0;
      cycles(1);
      if (i == 998) checkOutput("score_at_max", 32'(score), 32'(exp_score));
    end
    checkOutput("score_saturated", 32'(score), 32'(exp_score));
    lose_with_coin();
    run_dying();
    btn_ack = 1'b1;
    cycles(3);
    btn_ack = 1'b0;
    check_game("game3_ack", F_IDLE, 1'b0);
    cycles(3);

    $display("[TB] game 4: reset in DYING");
    start_game();
    run_countdown();
    coin_press(1, 1'b1);
    lose = 1'b1;
    cycles(1);
    lose = 1'b0;
    check_game("g4_dying", F_DYING, 1'b1);
    for (int i = 0; i < 10; i++) pulse_tick();
    reset_n = 1'b0;
    #2;
    exp_score  = 0;
    exp_hi     = 0;
    exp_new_hi = 0;
    check_game("mid_dying_reset", F_IDLE, 1'b0);
    checkOutput("mid_reset_cd", 32'(countdown), 32'd0);
    checkOutput("mid_reset_ack_pulse", 32'(ack_pulse), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    check_game("post_reset", F_IDLE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
